// File: rtl/pmem_arbiter_if.sv
// Line-sized physical-memory port bundle shared by both caches and main memory.
// master drives the request (read/write strobes, address, write line) and receives rdata/resp;
// slave is the memory-facing end that returns rdata and the one-cycle completion pulse.
interface pmem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [LINE_WIDTH-1:0] wdata;
    logic [LINE_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (
        output read, write, address, wdata,
        input  rdata, resp
    );

    modport slave (
        input  read, write, address, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache, one line transaction at a time.
// Latency: request seen in cycle N drives the memory strobe in cycle N+1; resp is forwarded combinationally.
// Backpressure: the losing requester simply holds its level request; it is re-sampled in the next IDLE cycle.
// Ports: clk/rst (async, active-high); i_pmem, d_pmem = cache-side slave ports;
//        pmem = memory-side master port; arb_busy = high while a transaction is outstanding.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128,
    parameter int RR_MODE    = 1
) (
    input  logic            clk,
    input  logic            rst,
    pmem_arbiter_if.slave   i_pmem,
    pmem_arbiter_if.slave   d_pmem,
    pmem_arbiter_if.master  pmem,
    output logic            arb_busy
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } state_t;

    state_t                state;
    logic                  last_grant_d;   // 0 = I served last, 1 = D served last
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic                  rd_q;
    logic                  wr_q;

    logic                  req_i;
    logic                  req_d;
    logic                  grant_d;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic                  sel_wr;

    // Grant selection; only consulted in IDLE.
    always_comb begin
        req_i   = i_pmem.read | i_pmem.write;
        req_d   = d_pmem.read | d_pmem.write;
        grant_d = req_d;
        if (req_i && req_d) begin
            grant_d = (RR_MODE != 0) ? !last_grant_d : 1'b1;
        end
        sel_addr  = grant_d ? d_pmem.address : i_pmem.address;
        sel_wdata = grant_d ? d_pmem.wdata   : i_pmem.wdata;
        // read+write together is illegal; treating it as a write keeps dirty data safe
        sel_wr    = grant_d ? d_pmem.write   : i_pmem.write;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            arb_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i || req_d) begin
                        state    <= grant_d ? BUSY_D : BUSY_I;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_wdata;
                        rd_q     <= !sel_wr;
                        wr_q     <= sel_wr;
                        arb_busy <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Always return through IDLE so the requester can drop its level
                    // request after resp before it is sampled again.
                    if (pmem.resp) begin
                        state        <= IDLE;
                        last_grant_d <= (state == BUSY_D);
                        rd_q         <= 1'b0;
                        wr_q         <= 1'b0;
                        arb_busy     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pmem.read    = rd_q;
    assign pmem.write   = wr_q;
    assign pmem.address = addr_q;
    assign pmem.wdata   = wdata_q;

    // Read line is shared; it is only meaningful while the matching resp is high.
    assign i_pmem.rdata = pmem.rdata;
    assign d_pmem.rdata = pmem.rdata;

    // Responses stray from memory in IDLE never reach either cache.
    assign i_pmem.resp  = (state == BUSY_I) && pmem.resp;
    assign d_pmem.resp  = (state == BUSY_D) && pmem.resp;

    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(i_pmem.read && i_pmem.write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_pmem.read && d_pmem.write));

endmodule
